neuron_driver: RTL and testbench

NEURON_DRIVER -- requirements
Module: neuron_driver

---
 rtl/neuron_driver.sv | 157 +++++++++++++++
 tb/tb_neuron_driver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_driver.sv
// neuron_driver
//   Collects NUM_INPUTS serial samples into a parallel vector. It then sends a
//   one-cycle start pulse to the neuron, waits for the neuron's result, and
//   holds that result until downstream accepts it.
//
//   Optional feature: define NEURON_DRIVER_TIMEOUT_EN to enable a WAIT-state
//   watchdog. If the watchdog expires, the FSM abandons the evaluation and
//   timeout_error is set.
//
// Ports
//   clock, reset_n              clock (rising edge), async active-low reset
//   in_valid, in_data, in_ready serial sample handshake
//   neuron_inputs               parallel vector to the neuron
//   neuron_input_ready          start pulse to the neuron
//   neuron_out                  neuron result
//   neuron_output_ready         neuron result strobe
//   result_valid, result_data,
//   result_ready                captured-result handshake
//   busy                        high when the FSM is not in LOAD
//   timeout_error               sticky watchdog flag, cleared by the next accept
//
// state | meaning
// LOAD  | accepting serial samples into neuron_inputs
// FIRE  | one-cycle start pulse to the neuron
// WAIT  | waiting for neuron_output_ready (watchdog runs here when enabled)
// HOLD  | presenting result_data until result_ready

module neuron_driver #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_INPUTS     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] neuron_inputs [NUM_INPUTS],
  output logic                         neuron_input_ready,
  input  logic signed [DATA_WIDTH-1:0] neuron_out,
  input  logic                         neuron_output_ready,
  output logic                         result_valid,
  output logic signed [DATA_WIDTH-1:0] result_data,
  input  logic                         result_ready,
  output logic                         busy,
  output logic                         timeout_error
);

  localparam int CW = $clog2(NUM_INPUTS + 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] count;

`ifdef NEURON_DRIVER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
`else
  assign timeout_error = 1'b0;
`endif

  // All outputs are registered. Each one is updated together with the state
  // transition, so in_ready is a pure function of the state register and has
  // no combinational path from result_ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= LOAD;
      count              <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) neuron_inputs[i] <= '0;
      result_data        <= '0;
      result_valid       <= 1'b0;
      neuron_input_ready <= 1'b0;
      in_ready           <= 1'b1;
      busy               <= 1'b0;
`ifdef NEURON_DRIVER_TIMEOUT_EN
      wait_cnt           <= '0;
      timeout_error      <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            // A loop over all elements avoids indexing with the wider count.
            for (int i = 0; i < NUM_INPUTS; i++) begin
              if (count == CW'(i)) neuron_inputs[i] <= in_data;
            end
            count <= count + 1'b1;
`ifdef NEURON_DRIVER_TIMEOUT_EN
            timeout_error <= 1'b0;
`endif
            if (count == CW'(NUM_INPUTS - 1)) begin
              state              <= FIRE;
              neuron_input_ready <= 1'b1;
              in_ready           <= 1'b0;
              busy               <= 1'b1;
            end
          end
        end

        FIRE: begin
          state              <= WAIT;
          neuron_input_ready <= 1'b0;
`ifdef NEURON_DRIVER_TIMEOUT_EN
          wait_cnt           <= '0;
`endif
        end

        WAIT: begin
          // The neuron's result takes priority over the watchdog if both occur
          // in the same cycle.
          if (neuron_output_ready) begin
            state        <= HOLD;
            result_data  <= neuron_out;
            result_valid <= 1'b1;
          end
`ifdef NEURON_DRIVER_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state         <= LOAD;
            count         <= '0;
            in_ready      <= 1'b1;
            busy          <= 1'b0;
            timeout_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        HOLD: begin
          if (result_ready) begin
            state        <= LOAD;
            count        <= '0;
            result_valid <= 1'b0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
          end
        end

        default: begin
          state              <= LOAD;
          count              <= '0;
          result_valid       <= 1'b0;
          neuron_input_ready <= 1'b0;
          in_ready           <= 1'b1;
          busy               <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_driver.sv
module tb_neuron_driver;

  localparam int DW = 32;
  localparam int NI = 16;
  localparam int TO = 8;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_ready;
  logic signed [DW-1:0] neuron_inputs [NI];
  logic                 neuron_input_ready;
  logic signed [DW-1:0] neuron_out = '0;
  logic                 neuron_output_ready = 1'b0;
  logic                 result_valid;
  logic signed [DW-1:0] result_data;
  logic                 result_ready = 1'b0;
  logic                 busy;
  logic                 timeout_error;

  int checks = 0;
  int errors = 0;

  // Reference model state: the vector the neuron should see and the result
  // that should be presented downstream.
  logic signed [DW-1:0] exp_vec [NI];
  logic signed [DW-1:0] exp_res;

  neuron_driver #(
    .DATA_WIDTH(DW), .NUM_INPUTS(NI), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .neuron_inputs(neuron_inputs), .neuron_input_ready(neuron_input_ready),
    .neuron_out(neuron_out), .neuron_output_ready(neuron_output_ready),
    .result_valid(result_valid), .result_data(result_data),
    .result_ready(result_ready), .busy(busy), .timeout_error(timeout_error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode 0: random in_valid, 1: toggle 1,0,1,0, 2: held high
  task automatic load_vector(input int mode);
    int i = 0;
    int cyc = 0;
    bit phase = 1'b1;
    for (int j = 0; j < NI; j++) exp_vec[j] = DW'($urandom);
    while (i < NI && cyc < 200) begin
      case (mode)
        1:       in_valid = phase;
        2:       in_valid = 1'b1;
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      phase = ~phase;
      in_data = in_valid ? exp_vec[i] : DW'($urandom);
      neuron_output_ready = 1'($urandom_range(0, 1));
      neuron_out = DW'($urandom);
      result_ready = 1'($urandom_range(0, 1));
      check("in_ready_load", in_ready, 1);
      tick();
      cyc++;
      if (in_valid) begin
        i++;
        check("err_clear_on_accept", timeout_error, 0);
      end
      if (i < NI) check("no_early_fire", neuron_input_ready, 0);
    end
    check("load_budget", i, NI);
    // Keep in_valid high with junk data; it must be ignored outside LOAD.
    in_valid = 1'b1;
    in_data = DW'($urandom);
    check("fire_pulse", neuron_input_ready, 1);
    check("in_ready_fire", in_ready, 0);
    check("busy_fire", busy, 1);
    for (int j = 0; j < NI; j++) check($sformatf("vec%0d", j), neuron_inputs[j], exp_vec[j]);
  endtask

  // The bench is in the FIRE cycle (cycle 0) when this is called. The neuron
  // responds in cycle k, so result_valid is expected in cycle k+1.
  task automatic wait_result(input int k, input int hold);
    neuron_output_ready = 1'($urandom_range(0, 1));
    neuron_out = DW'($urandom);
    result_ready = 1'($urandom_range(0, 1));
    tick();
    check("fire_one_cycle", neuron_input_ready, 0);
    for (int c = 1; c < k; c++) begin
      neuron_output_ready = 1'b0;
      result_ready = 1'($urandom_range(0, 1));
      check("wait_busy", busy, 1);
      check("wait_no_result", result_valid, 0);
      check("wait_in_ready", in_ready, 0);
      check("wait_no_error", timeout_error, 0);
      tick();
    end
    exp_res = DW'($urandom);
    neuron_out = exp_res;
    neuron_output_ready = 1'b1;
    result_ready = 1'($urandom_range(0, 1));
    check("rv_before_latency", result_valid, 0);
    tick();
    neuron_output_ready = 1'b0;
    result_ready = 1'b0;
    check("rv_latency", result_valid, 1);
    for (int h = 0; h < hold; h++) begin
      neuron_output_ready = 1'($urandom_range(0, 1));
      neuron_out = DW'($urandom);
      check("hold_valid", result_valid, 1);
      check("hold_data", result_data, exp_res);
      check("hold_in_ready", in_ready, 0);
      tick();
    end
    neuron_output_ready = 1'b0;
    check("hold_data_last", result_data, exp_res);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("rv_after_accept", result_valid, 0);
    check("in_ready_after_accept", in_ready, 1);
    check("busy_after_accept", busy, 0);
    check("no_error_after_result", timeout_error, 0);
  endtask

  task automatic check_reset_values();
    check("rst_result_valid", result_valid, 0);
    check("rst_fire", neuron_input_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_error, 0);
    check("rst_result_data", result_data, 0);
    for (int j = 0; j < NI; j++) check($sformatf("rst_vec%0d", j), neuron_inputs[j], 0);
  endtask

  initial begin
    #2;
    check_reset_values();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("in_ready_post_reset", in_ready, 1);

    // Held-high load followed by a k=4 neuron and a 10-cycle hold.
    load_vector(2);
    wait_result(4, 10);

    // Backpressure with in_valid toggling.
    load_vector(1);
    wait_result(4, 3);

    // Randomized evaluations.
    repeat (6) begin
      load_vector(0);
      wait_result($urandom_range(1, TO), $urandom_range(0, 6));
    end

    // Result arrives on the last permitted WAIT cycle.
    load_vector(2);
    wait_result(TO, 2);

    // Mid-operation reset after 7 accepts.
    for (int j = 0; j < 7; j++) begin
      in_valid = 1'b1;
      in_data = DW'($urandom);
      tick();
      check("partial_no_fire", neuron_input_ready, 0);
    end
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("in_ready_after_midreset", in_ready, 1);
    check("no_fire_after_midreset", neuron_input_ready, 0);
    load_vector(0);
    wait_result(4, 1);

`ifdef NEURON_DRIVER_TIMEOUT_EN
    // The neuron never responds, so the watchdog fires after TO WAIT cycles.
    load_vector(2);
    in_valid = 1'b0;
    neuron_output_ready = 1'b0;
    tick();
    for (int c = 1; c <= TO; c++) begin
      check("to_wait_busy", busy, 1);
      check("to_no_error_yet", timeout_error, 0);
      tick();
    end
    check("to_error_set", timeout_error, 1);
    check("to_no_result", result_valid, 0);
    check("to_in_ready", in_ready, 1);
    check("to_busy_low", busy, 0);
    repeat (3) begin
      tick();
      check("to_error_sticky", timeout_error, 1);
      check("to_result_still_low", result_valid, 0);
    end
    load_vector(0);
    wait_result(4, 0);
`else
    // Without the watchdog, WAIT lasts indefinitely.
    load_vector(2);
    wait_result(40, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
